// File: rtl/uart_packet_parser.sv
// rtl/uart_packet_parser.sv - frames host bytes into command packets, echo stream and operands
// Header decode picks the payload path; payload bytes are counted down from length-4.
module uart_packet_parser #(
  parameter int DATA_WIDTH_P = 8,
  parameter int OPERAND_W_P  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    cmd_valid_o,
  output logic [7:0]              opcode_o,
  output logic [15:0]             length_o,
  output logic [DATA_WIDTH_P-1:0] echo_tdata_o,
  output logic                    echo_tvalid_o,
  input  logic                    echo_tready_i,
  output logic [OPERAND_W_P-1:0]  operand_o,
  output logic                    operand_valid_o,
  output logic                    operand_last_o,
  input  logic                    operand_ready_i,
  output logic                    err_o
);
  localparam int NB_P = OPERAND_W_P / 8;
  localparam int OBW_P = (NB_P > 1) ? $clog2(NB_P) : 1;
  localparam logic [OBW_P-1:0] OB_LAST_P = OBW_P'(NB_P - 1);

  typedef enum logic [1:0] {HEADER, ECHO, OPERAND, DRAIN} state_e;
  state_e state_q, state_d;

  logic [1:0]              hcnt_q;
  logic [7:0]              hdr_op_q, len_lo_q, opcode_q;
  logic [15:0]             rem_q, length_q;
  logic [OBW_P-1:0]        obyte_q;
  logic [OPERAND_W_P-9:0]  shift_q;
  logic [OPERAND_W_P-1:0]  operand_q;
  logic [DATA_WIDTH_P-1:0] echo_data_q;
  logic cmd_q, err_q, echo_valid_q, op_valid_q, op_last_q;

  logic        accept, hdr_done, is_echo, is_arith, hdr_legal, last_byte, op_load;
  logic [15:0] hdr_len;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign hdr_len   = {s_axis_tdata, len_lo_q};
  assign hdr_done  = accept && (state_q == HEADER) && (hcnt_q == 2'd3);
  assign is_echo   = (hdr_op_q == 8'hEC);
  assign is_arith  = (hdr_op_q == 8'h10) || (hdr_op_q == 8'h11) || (hdr_op_q == 8'h12);
  // length[1:0]==0 is the same test as (length-4) being a whole number of operands
  assign hdr_legal = (hdr_len >= 16'd4) &&
                     (is_echo || (is_arith && (hdr_len[1:0] == 2'b00) && (hdr_len >= 16'd12)));
  assign last_byte = accept && (rem_q == 16'd1);
  assign op_load   = accept && (state_q == OPERAND) && (obyte_q == OB_LAST_P);

  always_ff @(posedge clk) begin
    if (rst) state_q <= HEADER;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HEADER: begin
        if (hdr_done) begin
          if (hdr_legal && is_arith) state_d = OPERAND;
          else if (hdr_len > 16'd4)  state_d = hdr_legal ? ECHO : DRAIN;
        end
      end
      default: if (last_byte) state_d = HEADER;
    endcase
  end

  // Operand path only stalls the byte that would overwrite a still-pending operand
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      HEADER, DRAIN: s_axis_tready = 1'b1;
      ECHO:          s_axis_tready = !echo_valid_q || echo_tready_i;
      OPERAND:       s_axis_tready = !(op_valid_q && !operand_ready_i && (obyte_q == OB_LAST_P));
      default:       s_axis_tready = 1'b0;
    endcase
    if (rst) s_axis_tready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= 2'd0;        hdr_op_q <= 8'd0;   len_lo_q <= 8'd0;
      opcode_q <= 8'd0;      length_q <= 16'd0;  rem_q <= 16'd0;
      obyte_q <= '0;         shift_q <= '0;      operand_q <= '0;
      echo_data_q <= '0;     cmd_q <= 1'b0;      err_q <= 1'b0;
      echo_valid_q <= 1'b0;  op_valid_q <= 1'b0; op_last_q <= 1'b0;
    end else begin
      cmd_q <= 1'b0;
      err_q <= 1'b0;
      if (accept && (state_q == HEADER)) begin
        hcnt_q <= hcnt_q + 2'd1;
        if (hcnt_q == 2'd0) hdr_op_q <= s_axis_tdata;
        if (hcnt_q == 2'd2) len_lo_q <= s_axis_tdata;
      end
      if (hdr_done) begin
        opcode_q <= hdr_op_q;
        length_q <= hdr_len;
        cmd_q    <= hdr_legal;
        err_q    <= !hdr_legal;
        rem_q    <= hdr_len - 16'd4;
        obyte_q  <= '0;
      end else if (accept) begin
        rem_q <= rem_q - 16'd1;
      end
      if (accept && (state_q == OPERAND)) begin
        shift_q <= {s_axis_tdata, shift_q[OPERAND_W_P-9:8]};
        obyte_q <= obyte_q + OBW_P'(1);
      end
      if (accept && (state_q == ECHO)) begin
        echo_valid_q <= 1'b1;
        echo_data_q  <= s_axis_tdata;
      end else if (echo_tready_i) begin
        echo_valid_q <= 1'b0;
      end
      if (op_load) begin
        operand_q  <= {s_axis_tdata, shift_q};
        op_valid_q <= 1'b1;
        op_last_q  <= (rem_q == 16'd1);
      end else if (operand_ready_i) begin
        op_valid_q <= 1'b0;
        op_last_q  <= 1'b0;
      end
    end
  end

  assign cmd_valid_o     = cmd_q;
  assign err_o           = err_q;
  assign opcode_o        = opcode_q;
  assign length_o        = length_q;
  assign echo_tdata_o    = echo_data_q;
  assign echo_tvalid_o   = echo_valid_q;
  assign operand_o       = operand_q;
  assign operand_valid_o = op_valid_q;
  assign operand_last_o  = op_last_q;
endmodule
